// File: rtl/pc_pkg.sv
// Shared definitions for the popcount family: FSM state encoding, LUT geometry
// and the count-width helper.
package pc_pkg;

  localparam int LUT_AW = 8;
  localparam int LUT_DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold any count from 0 up to data_w inclusive.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/pc_lut_seq_if.sv
// Word-in / count-out valid-ready bus for the sequential popcount block.
interface pc_lut_seq_if #(
  parameter int DATA_W = 32
);
  import pc_pkg::*;

  localparam int CNT_W = cnt_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );

endinterface

// File: rtl/pc_lut_8bit.sv
// Combinational 8-bit popcount lookup table; the ROM contents are built at
// elaboration from the index bits.
module pc_lut_8bit
  import pc_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_DW-1:0] q
);

  logic [LUT_DW-1:0] rom [2**LUT_AW];

  for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
    localparam logic [LUT_AW-1:0] V = LUT_AW'(gi);
    assign rom[gi] = LUT_DW'(V[0]) + LUT_DW'(V[1]) + LUT_DW'(V[2]) + LUT_DW'(V[3])
                   + LUT_DW'(V[4]) + LUT_DW'(V[5]) + LUT_DW'(V[6]) + LUT_DW'(V[7]);
  end

  assign q = rom[addr];

endmodule

// File: rtl/pc_lut_seq.sv
// Sequential popcount: one byte per cycle through a shared 8-bit LUT, LSB byte first.
// Optional early termination on an all-zero remainder: PC_LUT_SEQ_EARLY_EXIT_EN.
module pc_lut_seq
  import pc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_lut_seq_if.slave   bus,
  output logic          busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = cnt_w(DATA_W);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
    $error("pc_lut_seq: DATA_W must be a multiple of 8 and at least 8");
  end

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  out_count_reg, out_count_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [LUT_DW-1:0] q;
  logic [CNT_W-1:0]  sum;
  logic              last_pass;

  pc_lut_8bit u_lut (
    .addr (shreg_reg[LUT_AW-1:0]),
    .q    (q)
  );

  assign sum = acc_reg + CNT_W'(q);

`ifdef PC_LUT_SEQ_EARLY_EXIT_EN
  // Nothing left above the current byte: this pass already completes the count.
  assign last_pass = (idx_reg == IDX_W'(NBYTES - 1)) || ((shreg_reg >> LUT_AW) == '0);
`else
  assign last_pass = (idx_reg == IDX_W'(NBYTES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      acc_reg       <= '0;
      out_count_reg <= '0;
      idx_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      acc_reg       <= acc_next;
      out_count_reg <= out_count_next;
      idx_reg       <= idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    acc_next       = acc_reg;
    out_count_next = out_count_reg;
    idx_next       = idx_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_next = bus.in_data;
          acc_next   = '0;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next   = sum;
        shreg_next = shreg_reg >> LUT_AW;
        idx_next   = idx_reg + 1'b1;
        if (last_pass) begin
          out_count_next = sum;
          state_next     = DONE;
        end
      end
      DONE: begin
        // Accepting a new word waits for the cycle after the output handshake.
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_count = out_count_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_pc_lut_seq.sv
// Directed bench for pc_lut_seq at DATA_W=32, plus short runs at DATA_W=8 and 64.
// Expected latencies follow PC_LUT_SEQ_EARLY_EXIT_EN when it is defined.
module tb_pc_lut_seq;

  logic clk;
  logic rst_n;
  logic busy, busy8, busy64;

  int n_vec = 0;
  int n_err = 0;

  pc_lut_seq_if #(.DATA_W(32)) bus   ();
  pc_lut_seq_if #(.DATA_W(8))  bus8  ();
  pc_lut_seq_if #(.DATA_W(64)) bus64 ();

  pc_lut_seq #(.DATA_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus),   .busy(busy));
  pc_lut_seq #(.DATA_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .busy(busy8));
  pc_lut_seq #(.DATA_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64), .busy(busy64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] d, input int nbytes);
    int l;
    l = nbytes;
`ifdef PC_LUT_SEQ_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < nbytes; i++)
      if (d[i*8 +: 8] != 8'h00) l = i + 1;
`endif
    return l;
  endfunction

  // Called just after a falling edge with the DUT idle; returns just after the
  // falling edge following the output handshake.
  task automatic run_word(input logic [31:0] d, input int exp, input int hold, input bit keep);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (keep) begin
      bus.in_data = 32'hFFFF_FFFF;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
    end
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_lat(d, 4));
    check("count", bus.out_count, exp);
    check("in_ready_done", bus.in_ready, 0);
    check("busy_done", busy, 1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_count", bus.out_count, exp);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_cleared", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w8;
    logic [63:0] w64;
    int k;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;   bus.in_data = '0;   bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0;  bus8.in_data = '0;  bus8.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.out_ready = 1'b1;

    #3;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_word(32'hFFFF_FFFF, 32, 0, 1'b0);
    run_word(32'h0000_0001, 1, 0, 1'b0);
    run_word(32'h0000_0000, 0, 0, 1'b0);
    run_word(32'h8000_0001, 2, 5, 1'b0);
    run_word(32'hA5A5_A5A5, 16, 0, 1'b1);
    run_word(32'h0F0F_0F0F, 16, 0, 1'b0);

    // Reset during RUN after two passes: the word must vanish.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_mid_run", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_out_count", bus.out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(32'h0000_00FF, 8, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      w8 = (n == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk);
      check("dw8_in_ready", bus8.in_ready, 1);
      bus8.in_valid = 1'b1;
      bus8.in_data  = w8;
      @(posedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      k = 0;
      while (!bus8.out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("dw8_latency", k, exp_lat(64'(w8), 1));
      check("dw8_count", bus8.out_count, $countones(w8));
    end

    for (int n = 0; n < 40; n++) begin
      w64 = (n == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      if (n == 1) w64 = 64'h0000_0000_0000_0100;
      @(negedge clk);
      check("dw64_in_ready", bus64.in_ready, 1);
      bus64.in_valid = 1'b1;
      bus64.in_data  = w64;
      @(posedge clk);
      @(negedge clk);
      bus64.in_valid = 1'b0;
      k = 0;
      while (!bus64.out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("dw64_latency", k, exp_lat(w64, 8));
      check("dw64_count", bus64.out_count, $countones(w64));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
